aes_block_buffer: RTL and testbench

//  Word/block staging buffer between the AHB-lite slave interface and the AES core.
//  RX path: assembles WORDS x WORD_W-bit words shifted in under controller ahb_shift_en/ahb_mode=0

---
 rtl/aes_block_buffer_if.sv | 46 ++++
 rtl/aes_block_buffer.sv | 177 +++++++++++++++++
 tb/tb_aes_block_buffer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_block_buffer_if.sv
// Bus bundle between the AHB-side controller and the AES block buffer.
//   clear     : synchronous abort of both paths
//   shift_en  : move one word this cycle (direction picked by ahb_mode)
//   ahb_mode  : 0 = RX (wdata in), 1 = TX (rdata out)
//   wdata     : word written into the RX buffer
//   rdata     : current TX word (combinational)
//   blk_out   : assembled block to the AES core, blk_valid/blk_ready handshake
//   res_in    : result block from the AES core, res_valid/res_ready handshake
//   rx_cnt    : words held in the RX buffer (0..WORDS)
//   tx_cnt    : words still to send from the TX buffer (0..WORDS)
//   rx_ovf    : sticky, an RX word was dropped
//   tx_udf    : sticky, a TX read happened with nothing to send
// slave = the buffer, master = the controller / AES core side.
interface aes_block_buffer_if #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 4
);
    localparam int BLK_W = WORD_W * WORDS;
    localparam int CNT_W = $clog2(WORDS + 1);

    logic              clear;
    logic              shift_en;
    logic              ahb_mode;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata;
    logic [BLK_W-1:0]  blk_out;
    logic              blk_valid;
    logic              blk_ready;
    logic [BLK_W-1:0]  res_in;
    logic              res_valid;
    logic              res_ready;
    logic [CNT_W-1:0]  rx_cnt;
    logic [CNT_W-1:0]  tx_cnt;
    logic              rx_ovf;
    logic              tx_udf;

    modport slave (
        input  clear, shift_en, ahb_mode, wdata, blk_ready, res_in, res_valid,
        output rdata, blk_out, blk_valid, res_ready, rx_cnt, tx_cnt, rx_ovf, tx_udf
    );

    modport master (
        output clear, shift_en, ahb_mode, wdata, blk_ready, res_in, res_valid,
        input  rdata, blk_out, blk_valid, res_ready, rx_cnt, tx_cnt, rx_ovf, tx_udf
    );
endinterface

// File: rtl/aes_block_buffer.sv
// Word/block staging buffer between the AHB-lite slave and the AES core.
// RX path collects WORDS words (first word = MSBs) into one block and offers it
// to the core with blk_valid/blk_ready. TX path captures a result block and
// hands it back one word per TX shift, MSB word first, with zero latency.
// Ports:
//   clk   : clock, rising edge
//   n_rst : asynchronous active-low reset
//   bus   : aes_block_buffer_if.slave (see interface file for signal list)
// WORDS must be at least 2.
module aes_block_buffer #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    aes_block_buffer_if.slave   bus
);
    localparam int BLK_W = WORD_W * WORDS;
    localparam int CNT_W = $clog2(WORDS + 1);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic {RX_FILL = 1'b0, RX_FULL = 1'b1} rx_state_t;
    typedef enum logic {TX_EMPTY = 1'b0, TX_DRAIN = 1'b1} tx_state_t;

    rx_state_t         rx_state_q, rx_state_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [WORD_W-1:0] rx_slot_q [WORDS];
    logic [WORD_W-1:0] rx_slot_d [WORDS];
    logic              rx_ovf_q, rx_ovf_d;

    tx_state_t         tx_state_q, tx_state_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [BLK_W-1:0]  tx_buf_q, tx_buf_d;
    logic              tx_udf_q, tx_udf_d;

    logic              rx_wr;
    logic              tx_rd;
    logic [BLK_W-1:0]  blk_out;
    logic [WORD_W-1:0] tx_word [WORDS];
    logic [IDX_W-1:0]  tx_idx;

    assign rx_wr = bus.shift_en & ~bus.ahb_mode;
    assign tx_rd = bus.shift_en & bus.ahb_mode;

    // ---------------- RX path ----------------
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_slot_d  = rx_slot_q;
        rx_ovf_d   = rx_ovf_q;
        if (bus.clear) begin
            rx_state_d = RX_FILL;
            rx_cnt_d   = '0;
            rx_ovf_d   = 1'b0;
            for (int i = 0; i < WORDS; i++) rx_slot_d[i] = '0;
        end else begin
            case (rx_state_q)
                RX_FILL: begin
                    if (rx_wr) begin
                        rx_slot_d[rx_cnt_q[IDX_W-1:0]] = bus.wdata;
                        if (rx_cnt_q == CNT_W'(WORDS - 1)) begin
                            rx_state_d = RX_FULL;
                            rx_cnt_d   = CNT_W'(WORDS);
                        end else begin
                            rx_cnt_d = rx_cnt_q + 1'b1;
                        end
                    end
                end
                RX_FULL: begin
                    if (bus.blk_ready) begin
                        // The consuming cycle also frees slot 0, so a word
                        // arriving on the same edge starts the next block.
                        rx_state_d = RX_FILL;
                        if (rx_wr) begin
                            rx_slot_d[0] = bus.wdata;
                            rx_cnt_d     = CNT_W'(1);
                        end else begin
                            rx_cnt_d = '0;
                        end
                    end else if (rx_wr) begin
                        rx_ovf_d = 1'b1;
                    end
                end
                default: rx_state_d = RX_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_state_q <= RX_FILL;
            rx_cnt_q   <= '0;
            rx_ovf_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_ovf_q   <= rx_ovf_d;
        end
    end

    // Slot 0 sits in the most significant word of blk_out.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_rx_slot
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) rx_slot_q[gi] <= '0;
                else        rx_slot_q[gi] <= rx_slot_d[gi];
            end
            assign blk_out[BLK_W-1-gi*WORD_W -: WORD_W] = rx_slot_q[gi];
        end
    endgenerate

    // ---------------- TX path ----------------
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_buf_d   = tx_buf_q;
        tx_udf_d   = tx_udf_q;
        if (bus.clear) begin
            tx_state_d = TX_EMPTY;
            tx_cnt_d   = '0;
            tx_buf_d   = '0;
            tx_udf_d   = 1'b0;
        end else begin
            case (tx_state_q)
                TX_EMPTY: begin
                    if (tx_rd) tx_udf_d = 1'b1;
                    if (bus.res_valid) begin
                        tx_buf_d   = bus.res_in;
                        tx_cnt_d   = CNT_W'(WORDS);
                        tx_state_d = TX_DRAIN;
                    end
                end
                TX_DRAIN: begin
                    // res_valid is deliberately ignored here; res_ready is low.
                    if (tx_rd) begin
                        tx_cnt_d = tx_cnt_q - 1'b1;
                        if (tx_cnt_q == CNT_W'(1)) tx_state_d = TX_EMPTY;
                    end
                end
                default: tx_state_d = TX_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tx_state_q <= TX_EMPTY;
            tx_cnt_q   <= '0;
            tx_buf_q   <= '0;
            tx_udf_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_buf_q   <= tx_buf_d;
            tx_udf_q   <= tx_udf_d;
        end
    end

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_tx_word
            assign tx_word[gi] = tx_buf_q[BLK_W-1-gi*WORD_W -: WORD_W];
        end
    endgenerate

    // Words already sent = WORDS - tx_cnt, which is the next word to present.
    assign tx_idx = IDX_W'(CNT_W'(WORDS) - tx_cnt_q);

    // ---------------- outputs ----------------
    assign bus.blk_out   = blk_out;
    assign bus.blk_valid = (rx_state_q == RX_FULL);
    assign bus.rx_cnt    = rx_cnt_q;
    assign bus.rx_ovf    = rx_ovf_q;
    assign bus.rdata     = (tx_state_q == TX_DRAIN) ? tx_word[tx_idx] : '0;
    assign bus.res_ready = (tx_cnt_q == '0);
    assign bus.tx_cnt    = tx_cnt_q;
    assign bus.tx_udf    = tx_udf_q;
endmodule

// File: tb/tb_aes_block_buffer.sv
module tb_aes_block_buffer;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    aes_block_buffer_if #(.WORD_W(32), .WORDS(4)) bus ();
    aes_block_buffer #(.WORD_W(32), .WORDS(4)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

    int checks = 0;
    int failures = 0;
    int n_blk = 0;
    int n_word = 0;
    bit mon_en = 0;

    // Reference model: RX buffer is a queue of held words, TX buffer a queue of words left.
    logic [31:0]  m_rxq[$];
    logic [31:0]  m_txq[$];
    bit           m_ovf, m_udf, m_zero;
    logic [127:0] sb_blk[$];
    logic [31:0]  sb_word[$];

    // Expected status for the current cycle, taken before the model advances.
    int           exp_rx_cnt, exp_tx_cnt;
    bit           exp_blk_valid, exp_res_ready, exp_ovf, exp_udf;
    logic [127:0] exp_held, exp_mask;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        m_rxq.delete(); m_txq.delete(); sb_blk.delete();
        m_ovf = 0; m_udf = 0; m_zero = 1;
    endfunction

    function automatic void snapshot();
        exp_rx_cnt    = m_rxq.size();
        exp_blk_valid = (m_rxq.size() == 4);
        exp_tx_cnt    = m_txq.size();
        exp_res_ready = (m_txq.size() == 0);
        exp_ovf = m_ovf; exp_udf = m_udf;
        exp_held = '0; exp_mask = '0;
        if (m_zero) exp_mask = '1;
        else for (int i = 0; i < m_rxq.size(); i++) begin
            exp_held[127-32*i -: 32] = m_rxq[i];
            exp_mask[127-32*i -: 32] = 32'hFFFF_FFFF;
        end
    endfunction

    function automatic void model_update(input logic s, input logic m, input logic [31:0] wd,
                                         input logic br, input logic rv, input logic [127:0] ri,
                                         input logic clr);
        if (clr) begin model_clear(); return; end
        // RX
        if (m_rxq.size() == 4) begin
            if (br) begin
                m_rxq.delete();
                if (s && !m) begin m_rxq.push_back(wd); m_zero = 0; end
            end else if (s && !m) m_ovf = 1;
        end else if (s && !m) begin
            m_rxq.push_back(wd); m_zero = 0;
            if (m_rxq.size() == 4) sb_blk.push_back({m_rxq[0], m_rxq[1], m_rxq[2], m_rxq[3]});
        end
        // TX
        if (m_txq.size() == 0) begin
            if (s && m) begin sb_word.push_back(32'h0); m_udf = 1; end
            if (rv) for (int i = 0; i < 4; i++) m_txq.push_back(ri[127-32*i -: 32]);
        end else if (s && m) begin
            sb_word.push_back(m_txq.pop_front());
        end
    endfunction

    // Called at posedge+1: apply inputs for one cycle and advance the model.
    task automatic step(input logic s, input logic m, input logic [31:0] wd, input logic br,
                        input logic rv, input logic [127:0] ri, input logic clr);
        snapshot();
        bus.shift_en = s; bus.ahb_mode = m; bus.wdata = wd;
        bus.blk_ready = br; bus.res_valid = rv; bus.res_in = ri; bus.clear = clr;
        model_update(s, m, wd, br, rv, ri, clr);
        @(posedge clk); #1;
    endtask

    task automatic idle(); step(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic rx(input logic [31:0] w); step(1, 0, w, 0, 0, 0, 0); endtask
    task automatic txr(); step(1, 1, 0, 0, 0, 0, 0); endtask

    task automatic do_reset();
        n_rst = 0;
        bus.shift_en = 0; bus.ahb_mode = 0; bus.wdata = 0; bus.blk_ready = 0;
        bus.res_valid = 0; bus.res_in = 0; bus.clear = 0;
        model_clear();
        snapshot();
        repeat (2) @(posedge clk);
        #1 n_rst = 1;
    endtask

    // Monitor: status every cycle, transactions popped from the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("rx_cnt", 128'(bus.rx_cnt), 128'(exp_rx_cnt));
            chk("tx_cnt", 128'(bus.tx_cnt), 128'(exp_tx_cnt));
            chk("blk_valid", 128'(bus.blk_valid), 128'(exp_blk_valid));
            chk("res_ready", 128'(bus.res_ready), 128'(exp_res_ready));
            chk("rx_ovf", 128'(bus.rx_ovf), 128'(exp_ovf));
            chk("tx_udf", 128'(bus.tx_udf), 128'(exp_udf));
            chk("blk_slots", bus.blk_out & exp_mask, exp_held);
            if (exp_res_ready) chk("rdata_idle", 128'(bus.rdata), 128'h0);
            if (n_rst && !bus.clear && bus.shift_en && bus.ahb_mode) begin
                if (sb_word.size() == 0) chk("tx_word_expected", 128'(1), 128'(0));
                else begin
                    logic [31:0] w;
                    w = sb_word.pop_front();
                    n_word++;
                    $display("TX word #%0d rdata=%h exp=%h", n_word, bus.rdata, w);
                    chk("tx_word", 128'(bus.rdata), 128'(w));
                end
            end
            if (n_rst && !bus.clear && bus.blk_valid && bus.blk_ready) begin
                if (sb_blk.size() == 0) chk("blk_expected", 128'(1), 128'(0));
                else begin
                    logic [127:0] b;
                    b = sb_blk.pop_front();
                    n_blk++;
                    $display("RX blk #%0d blk_out=%h exp=%h", n_blk, bus.blk_out, b);
                    chk("blk_out", bus.blk_out, b);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] r;
        do_reset();
        mon_en = 1;
        idle();
        // 1: RX fill and consume
        rx(32'h00112233); rx(32'h44556677); rx(32'h8899AABB); rx(32'hCCDDEEFF);
        idle();
        step(0, 0, 0, 1, 0, 0, 0);
        idle();
        // 2: overflow, then consume + store in the same cycle
        rx(32'h11111111); rx(32'h22222222); rx(32'h33333333); rx(32'h44444444);
        rx(32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 0, 1);
        rx(32'h55555555); rx(32'h66666666); rx(32'h77777777); rx(32'h88888888);
        step(1, 0, 32'hDEADBEEF, 1, 0, 0, 0);
        rx(32'hA0A0A0A0); rx(32'hB0B0B0B0); rx(32'hC0C0C0C0);
        step(0, 0, 0, 1, 0, 0, 0);
        // 3: TX drain
        step(0, 0, 0, 0, 1, 128'h0123456789ABCDEF_FEDCBA9876543210, 0);
        txr(); txr(); txr(); txr();
        idle();
        // 4: underflow, then res_valid during drain is ignored
        txr();
        step(0, 0, 0, 0, 1, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, 0);
        step(1, 1, 0, 0, 1, 128'h99999999_99999999_99999999_99999999, 0);
        step(0, 0, 0, 0, 1, 128'h99999999_99999999_99999999_99999999, 0);
        txr(); txr(); txr();
        step(0, 0, 0, 0, 0, 0, 1);
        // 5: clear mid-operation, then reset mid-operation
        for (int k = 0; k < 2; k++) begin
            rx(32'h12345678); rx(32'h9ABCDEF0);
            step(0, 0, 0, 0, 1, 128'hCAFEF00D_0BADC0DE_FEEDFACE_DEADBEEF, 0);
            txr();
            if (k == 0) step(0, 0, 0, 0, 0, 0, 1);
            else begin do_reset(); idle(); end
            rx(32'h01010101); rx(32'h02020202); rx(32'h03030303); rx(32'h04040404);
            step(0, 0, 0, 1, 0, 0, 0);
        end
        // 6: interleaved RX fill and TX drain
        step(0, 0, 0, 0, 1, 128'h10203040_50607080_90A0B0C0_D0E0F000, 0);
        for (int k = 0; k < 4; k++) begin
            rx(32'hF0000000 + 32'(k));
            txr();
        end
        step(0, 0, 0, 1, 0, 0, 0);
        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            logic s, m, br, rv, clr;
            clr = ($urandom_range(63) == 0);
            s   = clr ? 1'b0 : 1'($urandom_range(1));
            m   = 1'($urandom_range(1));
            br  = ($urandom_range(3) == 0);
            rv  = ($urandom_range(3) == 0);
            r   = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(199) == 0) begin do_reset(); idle(); end
            else step(s, m, $urandom, br, rv, r, clr);
        end
        // flush anything still pending
        for (int k = 0; k < 6; k++) step(1, 1, 0, 1, 0, 0, 0);
        @(negedge clk);
        chk("sb_blk_drained", 128'(sb_blk.size()), 128'(0));
        chk("sb_word_drained", 128'(sb_word.size()), 128'(0));
        chk("blk_seen", 128'(n_blk > 8), 128'(1));
        chk("word_seen", 128'(n_word > 16), 128'(1));
        mon_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
